// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, display-area flag and frame
// boundary from an incoming active-low h_sync/v_sync pair sampled once per
// pixel clock, and tracks whether the stream matches the configured timing.
//
// Ports:
//   clk          pixel clock, one sync sample per rising edge
//   reset        asynchronous active-low reset
//   h_sync       horizontal sync, active-low
//   v_sync       vertical sync, active-low
//   x_pos        x of the pixel sampled on the previous edge
//   y_pos        line number of that pixel
//   display_area locked and pixel inside the visible window
//   frame_start  one-cycle pulse when the position becomes (0,0) while locked
//   locked       timing verified over LOCK_FRAMES consecutive frames
//   sync_error   one-cycle pulse on a timing violation while verifying/locked
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       display_area,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_error
);

  localparam int unsigned XW  = 10;
  localparam int unsigned WDW = 11;
  localparam int unsigned CW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [XW-1:0]  H_SYNC_X = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0]  H_PRE_X  = XW'(H_ACTIVE + H_FRONT - 1);
  localparam logic [XW-1:0]  H_LAST_X = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0]  H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [XW-1:0]  V_SYNC_Y = XW'(V_ACTIVE + V_FRONT);
  localparam logic [XW-1:0]  V_PRE_Y  = XW'(V_ACTIVE + V_FRONT - 1);
  localparam logic [XW-1:0]  V_LAST_Y = XW'(V_TOTAL - 1);
  localparam logic [XW-1:0]  V_ACT_Y  = XW'(V_ACTIVE);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(2 * H_TOTAL);
  localparam logic [WDW-1:0] WD_MAX   = '1;
  localparam logic [CW-1:0]  LOCK_CNT = CW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [WDW-1:0] wd_q, wd_d;
  logic           hs_prev, vs_prev;
  logic           h_fall, v_fall, h_ok, v_ok, x_wrap, wd_expired, violation;
  logic [XW-1:0]  x_d, y_d;
  logic           lock_d, err_d, disp_d, fs_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // Edge detection, counter reconstruction, timing checks and next state
  always_comb begin
    h_fall     = hs_prev & ~h_sync;
    v_fall     = vs_prev & ~v_sync;
    // Checks look at the counters before this edge updates them
    h_ok       = (x_pos == H_PRE_X);
    v_ok       = (y_pos == V_PRE_Y) || (y_pos == V_SYNC_Y);
    x_wrap     = (x_pos == H_LAST_X);
    wd_expired = (wd_q >= WD_LIMIT);
    violation  = (h_fall && !h_ok) || (v_fall && !v_ok) || wd_expired;

    x_d = x_pos + XW'(1);
    if (h_fall)      x_d = H_SYNC_X;
    else if (x_wrap) x_d = '0;

    // v_fall realignment wins over a same-cycle line increment
    y_d = y_pos;
    if (v_fall)                 y_d = V_SYNC_Y;
    else if (x_wrap && !h_fall) y_d = (y_pos == V_LAST_Y) ? '0 : y_pos + XW'(1);

    wd_d = wd_q;
    if (h_fall)            wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + WDW'(1);

    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (v_fall) begin
          state_d = VERIFY;
          cnt_d   = '0;
        end
      end
      VERIFY: begin
        if (violation) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (v_fall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LOCK_CNT) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (violation) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    lock_d = (state_d == LOCKED);
    disp_d = lock_d && (x_d < H_ACT_X) && (y_d < V_ACT_Y);
    fs_d   = lock_d && (x_d == '0) && (y_d == '0);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      wd_q         <= '0;
      hs_prev      <= 1'b1;
      vs_prev      <= 1'b1;
      x_pos        <= '0;
      y_pos        <= '0;
      display_area <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      hs_prev      <= h_sync;
      vs_prev      <= v_sync;
      x_pos        <= x_d;
      y_pos        <= y_d;
      display_area <= disp_d;
      frame_start  <= fs_d;
      locked       <= lock_d;
      sync_error   <= err_d;
    end
  end

endmodule
